// File: rtl/alarm_multi.sv
// alarm_multi: N-channel edge-triggered alarm with timed ring, snooze and auto-timeout.
module alarm_multi #(
  parameter int N_ALARMS   = 4,
  parameter int BUZZ_SEC   = 60,
  parameter int SNOOZE_MIN = 9,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [6:0]            tmin,
  input  logic [6:0]            thrs,
  input  logic                  tpm,
  input  logic [7*N_ALARMS-1:0] amin,
  input  logic [7*N_ALARMS-1:0] ahrs,
  input  logic [N_ALARMS-1:0]   apm,
  input  logic [N_ALARMS-1:0]   aen,
  input  logic                  sec_tick,
  input  logic                  min_tick,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  buzz,
  output logic [N_ALARMS-1:0]   ringing,
  output logic [N_ALARMS-1:0]   snoozed
);
  localparam int RW = $clog2(BUZZ_SEC + 1);
  localparam int SW = $clog2(SNOOZE_MIN + 1);
  localparam int CW = MAX_SNOOZE > 0 ? $clog2(MAX_SNOOZE + 1) : 1;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    state_t st, nst;
    logic [RW-1:0] rc, rc_n;
    logic [SW-1:0] sc, sc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic match, match_d, trig;
    assign match = aen[i] & (tmin == amin[7*i +: 7]) & (thrs == ahrs[7*i +: 7]) & (tpm == apm[i]);
    assign trig  = match & ~match_d;
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        st      <= IDLE;
        rc      <= '0;
        sc      <= '0;
        cnt     <= '0;
        match_d <= 1'b0;
      end else begin
        st      <= nst;
        rc      <= rc_n;
        sc      <= sc_n;
        cnt     <= cnt_n;
        match_d <= match;
      end
    end
    // Disable overrides all; within each state the pulses are checked in priority order.
    always_comb begin
      nst   = st;
      rc_n  = rc;
      sc_n  = sc;
      cnt_n = cnt;
      if (!aen[i]) nst = IDLE;
      else case (st)
        IDLE: if (trig) begin
          nst   = RINGING;
          rc_n  = RW'(BUZZ_SEC);
          cnt_n = '0;
        end
        RINGING: if (dismiss) nst = IDLE;
        else if (snooze && cnt < CW'(MAX_SNOOZE)) begin
          nst   = SNOOZED;
          sc_n  = SW'(SNOOZE_MIN);
          cnt_n = cnt + 1'b1;
        end else if (snooze) nst = IDLE;
        else if (sec_tick) begin
          nst  = rc == RW'(1) ? IDLE : RINGING;
          rc_n = rc - 1'b1;
        end
        SNOOZED: if (dismiss) nst = IDLE;
        else if (min_tick) begin
          nst  = sc == SW'(1) ? RINGING : SNOOZED;
          sc_n = sc - 1'b1;
          rc_n = sc == SW'(1) ? RW'(BUZZ_SEC) : rc;
        end
        default: nst = IDLE;
      endcase
    end
    assign ringing[i] = st == RINGING;
    assign snoozed[i] = st == SNOOZED;
  end
  assign buzz = |ringing;
endmodule

// File: tb/tb_alarm_multi.sv
// tb_alarm_multi: directed test-plan scenarios plus random traffic, scoreboarded per cycle against a behavioural model.
module tb_alarm_multi;
  localparam int N = 4, BS = 3, SM = 9, MS = 3;
  logic Clk = 0, Reset = 1;
  logic [6:0] tmin = 0, thrs = 5;
  logic tpm = 0;
  logic [7*N-1:0] amin = '0, ahrs = '0;
  logic [N-1:0] apm = '0, aen = '0;
  logic sec_tick = 0, min_tick = 0, snooze = 0, dismiss = 0;
  logic buzz;
  logic [N-1:0] ringing, snoozed;
  int tests = 0, fails = 0;
  logic [2*N:0] exp_q[$];
  int md[N], rs[N], sm[N], nz[N];
  bit pm[N];

  alarm_multi #(.N_ALARMS(N), .BUZZ_SEC(BS), .SNOOZE_MIN(SM), .MAX_SNOOZE(MS)) dut (
    .Clk(Clk), .Reset(Reset), .tmin(tmin), .thrs(thrs), .tpm(tpm), .amin(amin), .ahrs(ahrs),
    .apm(apm), .aen(aen), .sec_tick(sec_tick), .min_tick(min_tick), .snooze(snooze),
    .dismiss(dismiss), .buzz(buzz), .ringing(ringing), .snoozed(snoozed));

  always #5 Clk = ~Clk;

  // Model modes: 0 idle, 1 ringing, 2 snoozed; rs = seconds left, sm = minutes left, nz = snoozes used.
  task automatic model_step();
    logic [N-1:0] r, s;
    for (int i = 0; i < N; i++) begin
      bit m, t;
      if (Reset) begin
        md[i] = 0; pm[i] = 0;
      end else begin
        m = aen[i] && amin[7*i +: 7] == tmin && ahrs[7*i +: 7] == thrs && apm[i] == tpm;
        t = m && !pm[i];
        pm[i] = m;
        if (!aen[i]) md[i] = 0;
        else if (md[i] == 0) begin
          if (t) begin md[i] = 1; rs[i] = BS; nz[i] = 0; end
        end else if (md[i] == 1) begin
          if (dismiss) md[i] = 0;
          else if (snooze) begin
            if (nz[i] < MS) begin md[i] = 2; sm[i] = SM; nz[i]++; end
            else md[i] = 0;
          end else if (sec_tick) begin
            rs[i]--;
            if (rs[i] == 0) md[i] = 0;
          end
        end else begin
          if (dismiss) md[i] = 0;
          else if (min_tick) begin
            sm[i]--;
            if (sm[i] == 0) begin md[i] = 1; rs[i] = BS; end
          end
        end
      end
      r[i] = md[i] == 1;
      s[i] = md[i] == 2;
    end
    exp_q.push_back({|r, r, s});
  endtask

  task automatic tick();
    model_step();
    @(negedge Clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_time(input int h, input int m, input bit p);
    thrs = 7'(h); tmin = 7'(m); tpm = p;
  endtask

  task automatic set_alarm(input int i, input int h, input int m, input bit p, input bit en);
    ahrs[7*i +: 7] = 7'(h); amin[7*i +: 7] = 7'(m); apm[i] = p; aen[i] = en;
  endtask

  task automatic p_sec(); sec_tick = 1; tick(); sec_tick = 0; tick(); endtask
  task automatic p_min(); min_tick = 1; tick(); min_tick = 0; tick(); endtask
  task automatic p_snz(); snooze = 1; tick(); snooze = 0; tick(); endtask
  task automatic p_dis(); dismiss = 1; tick(); dismiss = 0; tick(); endtask

  task automatic check_now(input string name, input logic [2*N:0] exp_v);
    tests++;
    if ({buzz, ringing, snoozed} !== exp_v) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, {buzz, ringing, snoozed}, exp_v);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [2*N:0] e;
      e = exp_q.pop_front();
      tests++;
      if ({buzz, ringing, snoozed} !== e) begin
        fails++;
        $display("FAIL outputs@%0t: got buzz/ring/snz %b expected %b", $time, {buzz, ringing, snoozed}, e);
      end
    end
  end

  initial begin
    @(negedge Clk); #1;
    ticks(2);
    check_now("reset_state", '0);
    Reset = 0;
    set_time(5, 0, 0);
    ticks(2);
    // Basic ring and timeout, no retrigger while the minute holds.
    set_alarm(0, 6, 30, 0, 1);
    tick();
    set_time(6, 30, 0);
    ticks(3);
    p_sec(); p_sec(); p_sec();
    ticks(4);
    // Snooze cycling up to the limit.
    set_time(8, 0, 0);
    set_alarm(1, 8, 15, 0, 1);
    tick();
    set_time(8, 15, 0);
    ticks(2);
    for (int k = 0; k < MS; k++) begin
      p_snz();
      for (int j = 0; j < SM; j++) p_min();
      tick();
    end
    p_snz();
    ticks(2);
    // Dismiss beats snooze; dismiss while snoozed; same minute stays quiet.
    set_time(8, 16, 0); tick();
    set_time(8, 15, 0); ticks(2);
    snooze = 1; dismiss = 1; tick(); snooze = 0; dismiss = 0; ticks(2);
    set_time(8, 16, 0); tick();
    set_time(8, 15, 0); ticks(2);
    p_snz(); p_min(); p_dis(); p_min(); ticks(2);
    // Two channels on the same time; disabling one leaves the other.
    set_alarm(0, 11, 59, 1, 1);
    set_alarm(2, 11, 59, 1, 1);
    tick();
    set_time(11, 59, 1);
    ticks(2);
    aen[2] = 0;
    ticks(2);
    p_dis();
    // PM mismatch, then async reset mid-ring and re-trigger after release.
    set_alarm(3, 7, 0, 1, 1);
    set_time(7, 0, 0);
    ticks(3);
    set_time(7, 0, 1);
    ticks(2);
    #2 Reset = 1;
    #1 check_now("async_reset", '0);
    ticks(1);
    Reset = 0;
    ticks(3);
    p_dis();
    // Random traffic around the programmed alarm times.
    aen = '1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: set_time(6, 30, 0);
          1: set_time(8, 15, 0);
          2: set_time(11, 59, 1);
          3: set_time(7, 0, 1);
          4: set_time(7, 0, 0);
          default: set_time(1, 1, 0);
        endcase
      end
      sec_tick = $urandom_range(0, 2) == 0;
      min_tick = $urandom_range(0, 7) == 0;
      snooze   = $urandom_range(0, 19) == 0;
      dismiss  = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 99) == 0) aen[$urandom_range(0, N-1)] ^= 1'b1;
      Reset = $urandom_range(0, 399) == 0;
      tick();
    end
    Reset = 0; sec_tick = 0; min_tick = 0; snooze = 0; dismiss = 0;
    repeat (3) @(negedge Clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alarm_multi.md
# alarm_multi

Multi-channel alarm controller for the digital clock datapath: compares the running time (hours, minutes, AM/PM) against N independently enabled alarm settings. It sequences each channel through ringing, snooze and auto-timeout, and drives a single `buzz` output to the display/annunciator. It replaces the single-channel combinational match with edge-triggered, timed, snoozable alarms.

## Interface
- `N_ALARMS`, default 4: number of alarm channels, 1..8.
- `BUZZ_SEC`, default 60: seconds a channel rings before auto-stopping, 1..255.
- `SNOOZE_MIN`, default 9: minutes a snoozed channel waits before re-ringing, 1..59.
- `MAX_SNOOZE`, default 3: snoozes allowed per trigger; further snooze acts as dismiss.
- `Clk`  in  1: system clock. All state changes on its rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `tmin`  in  7: current minutes, 0..59.
- `thrs`  in  7: current hours, 1..12.
- `tpm`  in  1: current PM flag.
- `amin`  in  7*N_ALARMS: alarm minutes. Channel i is `[7i+6:7i]`.
- `ahrs`  in  7*N_ALARMS: alarm hours, packed the same way.
- `apm`  in  N_ALARMS: alarm PM flag per channel.
- `aen`  in  N_ALARMS: channel enable.
- `sec_tick`  in  1: one-cycle pulse, once per second.
- `min_tick`  in  1: one-cycle pulse, once per minute.
- `snooze`  in  1: one-cycle pulse, snooze all ringing channels.
- `dismiss`  in  1: one-cycle pulse, silence all ringing and snoozed channels.
- `buzz`  out  1: OR of `ringing`.
- `ringing`  out  N_ALARMS: channel i is in RINGING.
- `snoozed`  out  N_ALARMS: channel i is in SNOOZED.

## Operation
- `match[i] = aen[i] & (tmin==amin_i) & (thrs==ahrs_i) & (tpm==apm[i])`. This is combinational.
- `match_d[i]` holds the registered match. `trig[i] = match[i] & ~match_d[i]` (rising edge only). A channel rings once per matching minute, even after dismiss within that minute.
- Each channel has states IDLE, RINGING and SNOOZED. It also has a ring counter (`$clog2(BUZZ_SEC+1)` bits), a snooze counter (`$clog2(SNOOZE_MIN+1)` bits) and a snooze count (`$clog2(MAX_SNOOZE+1)` bits).
- **IDLE:** on `trig`, go to RINGING. Load ring counter = BUZZ_SEC and snooze count = 0.
- **RINGING:** the following apply in this priority order.
  - `dismiss`: go to IDLE.
  - `snooze` with snooze count < MAX_SNOOZE: go to SNOOZED. Load snooze counter = SNOOZE_MIN and increment snooze count.
  - `snooze` with snooze count == MAX_SNOOZE: go to IDLE.
  - `sec_tick` with ring counter == 1: go to IDLE (timeout).
  - `sec_tick` otherwise: decrement the ring counter.
- **SNOOZED:** the following apply in this priority order.
  - `dismiss`: go to IDLE.
  - `min_tick` with snooze counter == 1: go to RINGING and reload ring counter = BUZZ_SEC.
  - `min_tick` otherwise: decrement the snooze counter.
  - `trig` is ignored in this state.
- **Any state with `aen[i]` == 0:** go to IDLE. This overrides everything else.
- `snooze` and `dismiss` act only on channels already in the relevant state at that edge. A `trig` in the same cycle still starts ringing; the pulse does not cancel it.
- Channels are fully independent. Several channels may ring at once, and `buzz` is their OR.

## Timing
- **Reset values:** all states IDLE, counters 0, `match_d` = 0. Outputs `buzz`, `ringing` and `snoozed` are all 0.
- **Match after reset:** `match_d` is 0 after reset, so a match already true at the first clock triggers.
- **Output decoding:** outputs decode registered state only. No combinational path from inputs to outputs.
- **Ring latency:** `match` rises in cycle k → `ringing[i]` and `buzz` are high from cycle k+1.
- **Snooze latency:** `snooze` in cycle k → `ringing` low and `snoozed` high from cycle k+1. Exactly SNOOZE_MIN `min_tick`s later, `ringing` is high the cycle after the final tick.
- **Ring duration:** exactly BUZZ_SEC `sec_tick` pulses. `ringing` drops the cycle after the BUZZ_SEC-th tick.
- **Reset during operation:** `Reset` asserted while RINGING or SNOOZED clears `buzz` immediately (asynchronous). The alarm does not resume after release unless a new `trig` edge occurs.
- **Time wrap:** `thrs` 12→1 and `tpm` toggling need no special handling. Match is pure equality.

## Test plan
- **Basic ring and timeout:** ch0 = 6:30 AM, enabled, BUZZ_SEC=3. Time steps to 6:30 AM → `buzz` rises next cycle, stays high for 3 `sec_tick`s, then falls. It does not re-trigger while time stays at 6:30.
- **Snooze:** ch1 ringing; pulse `snooze` → `snoozed[1]`=1 and `buzz`=0. After 9 `min_tick`s, `ringing[1]`=1. Repeat snooze 3 times; the 4th `snooze` → IDLE with `buzz`=0.
- **Dismiss priority:** `snooze` and `dismiss` in the same cycle while ringing → IDLE, `snoozed`=0. `dismiss` while SNOOZED → IDLE. The same minute does not re-ring.
- **Multi-channel:** ch0 and ch2 both set to 11:59 PM → both `ringing` bits set in the same cycle. `aen[2]` cleared → only ch0 rings, `buzz` stays 1.
- **PM mismatch and reset:** alarm 7:00 PM while time is 7:00 AM → no buzz. Then `Reset` mid-ring → `buzz`=0 asynchronously; after release with the match still true, the channel rings again (`match_d` cleared).
